// File: rtl/fx3_gpif_sink.sv
// FX3 GPIF thread-0 slave-FIFO consumer: accepts 16-bit writes, models buffer fill/commit
// flag timing, counts overflows and checks the incrementing test-mode data pattern.
module fx3_gpif_sink #(
  parameter int BUFFER_WORDS  = 8192,
  parameter int WATERMARK     = 6,
  parameter int COMMIT_CYCLES = 16
) (
  input  logic        fx3_clock,
  input  logic        reset,
  input  logic        fx3_nWrite,
  input  logic [15:0] fx3_databus,
  input  logic        host_stall,
  input  logic        check_enable,
  output logic        fx3_th0Ready,
  output logic        fx3_th0Watermark,
  output logic [31:0] buffer_count,
  output logic [15:0] overflow_count,
  output logic [15:0] mismatch_count,
  output logic        mismatch_flag,
  output logic [15:0] last_word
);

  localparam int FW = $clog2(BUFFER_WORDS + 1);
  localparam int CW = $clog2(COMMIT_CYCLES + 1);
  localparam logic [FW-1:0] FILL_FULL   = FW'(BUFFER_WORDS);
  localparam logic [FW-1:0] FILL_THRESH = FW'(BUFFER_WORDS - WATERMARK);
  localparam logic [CW-1:0] COMMIT_LAST = CW'(COMMIT_CYCLES - 1);

  typedef enum logic {
    FILL   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t        state, state_d;
  logic [FW-1:0] fill_count, fill_d, fill_inc;
  logic [CW-1:0] commit_count, commit_d;
  logic          ready_d, watermark_d, buffer_done;
  logic          seed_valid;
  logic          accept, overflow_hit, pattern_error;

  // Ready is the registered flag, so a write seen while it is low is always dropped,
  // including the cycle right after the final word of a buffer.
  assign accept        = !fx3_nWrite && fx3_th0Ready;
  assign overflow_hit  = !fx3_nWrite && !fx3_th0Ready;
  assign fill_inc      = fill_count + 1'b1;
  assign pattern_error = accept && check_enable && seed_valid &&
                         (fx3_databus != last_word + 16'd1);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state;
    fill_d      = fill_count;
    commit_d    = commit_count;
    ready_d     = fx3_th0Ready;
    watermark_d = fx3_th0Watermark;
    buffer_done = 1'b0;
    unique case (state)
      FILL: begin
        ready_d = 1'b1;
        if (accept) begin
          fill_d = fill_inc;
          if (fill_inc >= FILL_THRESH) watermark_d = 1'b1;
          if (fill_inc == FILL_FULL) begin
            state_d     = COMMIT;
            ready_d     = 1'b0;
            buffer_done = 1'b1;
          end
        end
      end
      COMMIT: begin
        ready_d = 1'b0;
        if (commit_count == COMMIT_LAST) begin
          // Minimum commit time reached; a stalled host holds the buffer indefinitely.
          if (!host_stall) begin
            state_d     = FILL;
            fill_d      = '0;
            commit_d    = '0;
            ready_d     = 1'b1;
            watermark_d = 1'b0;
          end
        end else begin
          commit_d = commit_count + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge fx3_clock) begin
    if (reset) begin
      state            <= FILL;
      fill_count       <= '0;
      commit_count     <= '0;
      seed_valid       <= 1'b0;
      fx3_th0Ready     <= 1'b0;
      fx3_th0Watermark <= 1'b0;
      buffer_count     <= '0;
      overflow_count   <= '0;
      mismatch_count   <= '0;
      mismatch_flag    <= 1'b0;
      last_word        <= '0;
    end else begin
      state            <= state_d;
      fill_count       <= fill_d;
      commit_count     <= commit_d;
      fx3_th0Ready     <= ready_d;
      fx3_th0Watermark <= watermark_d;
      if (buffer_done) buffer_count <= buffer_count + 32'd1;
      if (overflow_hit && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 16'd1;
      if (pattern_error) begin
        mismatch_flag <= 1'b1;
        if (mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
      end
      if (accept) last_word <= fx3_databus;
      // Disabling the check always drops the seed, so the first word after re-enable only seeds.
      seed_valid <= check_enable && (accept || seed_valid);
    end
  end

endmodule

// File: tb/tb_fx3_gpif_sink.sv
// Directed bench for fx3_gpif_sink with a small buffer: table-driven fill/overflow/stall
// vectors, then hand-written pattern-check and mid-commit reset sequences.
module tb_fx3_gpif_sink;

  localparam int BW = 16;
  localparam int WM = 4;
  localparam int CC = 3;
  localparam int NV = 45;

  logic        clk;
  logic        reset;
  logic        nwrite;
  logic [15:0] data;
  logic        host_stall;
  logic        check_enable;
  logic        ready;
  logic        watermark;
  logic [31:0] buffer_count;
  logic [15:0] overflow_count;
  logic [15:0] mismatch_count;
  logic        mismatch_flag;
  logic [15:0] last_word;

  int checks   = 0;
  int failures = 0;

  fx3_gpif_sink #(
    .BUFFER_WORDS (BW),
    .WATERMARK    (WM),
    .COMMIT_CYCLES(CC)
  ) dut (
    .fx3_clock       (clk),
    .reset           (reset),
    .fx3_nWrite      (nwrite),
    .fx3_databus     (data),
    .host_stall      (host_stall),
    .check_enable    (check_enable),
    .fx3_th0Ready    (ready),
    .fx3_th0Watermark(watermark),
    .buffer_count    (buffer_count),
    .overflow_count  (overflow_count),
    .mismatch_count  (mismatch_count),
    .mismatch_flag   (mismatch_flag),
    .last_word       (last_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        nwrite;
    logic [15:0] data;
    logic        stall;
    logic        exp_ready;
    logic        exp_wm;
    logic [15:0] exp_last;
    logic [15:0] exp_ovf;
    logic [31:0] exp_buf;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_wm"}, 32'(watermark), 32'd0);
    check({tag, "_buf"}, buffer_count, 32'd0);
    check({tag, "_ovf"}, 32'(overflow_count), 32'd0);
    check({tag, "_mm"}, 32'(mismatch_count), 32'd0);
    check({tag, "_flag"}, 32'(mismatch_flag), 32'd0);
    check({tag, "_last"}, 32'(last_word), 32'd0);
  endtask

  // Waits (bounded) for ready, then presents one word for a single edge.
  task automatic send(input logic [15:0] w);
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("send_ready_wait", 32'(ready), 32'd1);
    nwrite = 1'b0;
    data   = w;
    step();
    nwrite = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_low;

    // Buffer 1, check off: 16 words, watermark after the 12th, ready drops after the 16th.
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b0, 16'(i), 1'b0, (i < 15), (i >= 11), 16'(i), 16'd0, (i == 15) ? 32'd1 : 32'd0};
    // Writes held through the 3 commit cycles are dropped; ready returns on the third edge.
    for (int k = 0; k < 3; k++)
      vecs[16+k] = '{1'b0, 16'h0100 + 16'(k), 1'b0, (k == 2), (k != 2), 16'h000F, 16'(k + 1), 32'd1};
    // First word of buffer 2 (fill 1), then fill to 15 with watermark after fill 12.
    vecs[19] = '{1'b0, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h0010, 16'd3, 32'd1};
    for (int j = 1; j <= 14; j++)
      vecs[19+j] = '{1'b0, 16'h0010 + 16'(j), 1'b0, 1'b1, (j >= 11), 16'h0010 + 16'(j), 16'd3, 32'd1};
    // Final word with host_stall already high: stall held for 10 edges keeps ready low 10 cycles.
    vecs[34] = '{1'b0, 16'h001F, 1'b1, 1'b0, 1'b1, 16'h001F, 16'd3, 32'd2};
    for (int s = 35; s <= 43; s++)
      vecs[s] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h001F, 16'd3, 32'd2};
    vecs[44] = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h001F, 16'd3, 32'd2};

    reset        = 1'b1;
    nwrite       = 1'b1;
    data         = '0;
    host_stall   = 1'b0;
    check_enable = 1'b0;

    // Reset held for two edges.
    @(negedge clk);
    step();
    check_all_zero("reset1");
    step();
    check_all_zero("reset2");
    reset = 1'b0;
    step();
    check("release_ready", 32'(ready), 32'd1);
    check("release_wm", 32'(watermark), 32'd0);

    stall_low = 0;
    for (int v = 0; v < NV; v++) begin
      nwrite     = vecs[v].nwrite;
      data       = vecs[v].data;
      host_stall = vecs[v].stall;
      step();
      check($sformatf("vec%0d_ready", v), 32'(ready), 32'(vecs[v].exp_ready));
      check($sformatf("vec%0d_wm", v), 32'(watermark), 32'(vecs[v].exp_wm));
      check($sformatf("vec%0d_last", v), 32'(last_word), 32'(vecs[v].exp_last));
      check($sformatf("vec%0d_ovf", v), 32'(overflow_count), 32'(vecs[v].exp_ovf));
      check($sformatf("vec%0d_buf", v), buffer_count, vecs[v].exp_buf);
      if (v >= 34 && ready === 1'b0) stall_low++;
    end
    nwrite     = 1'b1;
    host_stall = 1'b0;
    check("stall_ready_low_cycles", 32'(stall_low), 32'd10);
    check("table_mm", 32'(mismatch_count), 32'd0);

    // Pattern check across the 16-bit wrap, with one break at 0x0005.
    check_enable = 1'b1;
    send(16'hFFFE);
    check("pat_fffe_mm", 32'(mismatch_count), 32'd0);
    send(16'hFFFF);
    check("pat_ffff_mm", 32'(mismatch_count), 32'd0);
    send(16'h0000);
    check("pat_wrap_mm", 32'(mismatch_count), 32'd0);
    check("pat_wrap_flag", 32'(mismatch_flag), 32'd0);
    send(16'h0005);
    check("pat_0005_mm", 32'(mismatch_count), 32'd1);
    check("pat_0005_flag", 32'(mismatch_flag), 32'd1);
    send(16'h0006);
    check("pat_0006_mm", 32'(mismatch_count), 32'd1);
    check_enable = 1'b0;
    step();
    check_enable = 1'b1;
    send(16'h1234);
    check("reseed_mm", 32'(mismatch_count), 32'd1);
    check("reseed_flag", 32'(mismatch_flag), 32'd1);
    check("reseed_last", 32'(last_word), 32'h1234);

    // Buffer 3 holds 6 words; 10 more complete it, then reset during commit cycle 2.
    for (int i = 1; i <= 10; i++) send(16'h1234 + 16'(i));
    check("buf3_ready", 32'(ready), 32'd0);
    check("buf3_count", buffer_count, 32'd3);
    check("buf3_mm", 32'(mismatch_count), 32'd1);
    step();
    check("commit2_ready", 32'(ready), 32'd0);
    reset = 1'b1;
    step();
    check_all_zero("midreset");
    reset = 1'b0;
    step();
    check("midrel_ready", 32'(ready), 32'd1);
    check("midrel_wm", 32'(watermark), 32'd0);
    check("midrel_flag", 32'(mismatch_flag), 32'd0);
    send(16'hABCD);
    check("midrel_last", 32'(last_word), 32'hABCD);
    check("midrel_buf", buffer_count, 32'd0);
    check("midrel_ready2", 32'(ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fx3_gpif_sink.md
Name: fx3_gpif_sink

Overview:
- Synthesizable model of the FX3 GPIF thread-0 slave-FIFO consumer, i.e. the receiving end of the FPGA-to-FX3 16-bit write interface.
- Accepts words qualified by fx3_nWrite and drives the thread flags (fx3_th0Ready, fx3_th0Watermark) with buffer-fill and buffer-commit timing.
- Checks incoming data against the sequential test-mode pattern and counts errors.
- Used in loopback benches and on a second board to soak-test the capture path without a USB host.

Parameters:
- BUFFER_WORDS, 8192: words per DMA buffer; at least WATERMARK+2.
- WATERMARK, 6: remaining-space threshold in words at which fx3_th0Watermark asserts; at least 1.
- COMMIT_CYCLES, 16: minimum cycles fx3_th0Ready stays low while a full buffer is committed; at least 1.

Ports:
- fx3_clock  input  1  system clock (64 MHz); all logic on its rising edge.
- reset  input  1  synchronous reset, active-high.
- fx3_nWrite  input  1  0 = word on fx3_databus is written this cycle.
- fx3_databus  input  16  write data.
- host_stall  input  1  1 = host not draining; holds the commit phase beyond COMMIT_CYCLES.
- check_enable  input  1  1 = sequential-pattern checking active.
- fx3_th0Ready  output  1  1 = thread can accept a word this cycle.
- fx3_th0Watermark  output  1  1 = at most WATERMARK words of space remain in the current buffer.
- buffer_count  output  32  number of completed buffers, wraps modulo 2^32.
- overflow_count  output  16  writes attempted while fx3_th0Ready=0; saturates at 0xFFFF.
- mismatch_count  output  16  pattern errors; saturates at 0xFFFF.
- mismatch_flag  output  1  sticky; set on the first mismatch.
- last_word  output  16  most recent accepted word.

Behaviour:
- Reset (reset=1 at an edge):
  - State = FILL, fill counter = 0, commit counter = 0, seed_valid = 0.
  - All outputs = 0, including fx3_th0Ready.
  - Applies from any state; a commit in progress is abandoned.
  - The first edge after reset deasserts sets fx3_th0Ready = 1.
- All outputs are registered. A word is accepted at an edge where fx3_nWrite=0 and the registered fx3_th0Ready=1.
- FILL state:
  - Each accepted word increments the fill counter and loads last_word.
  - When an accepted word brings the fill count to at least BUFFER_WORDS-WATERMARK, fx3_th0Watermark = 1 from the next cycle. It stays 1 until the buffer switches.
  - When an accepted word brings the fill count to BUFFER_WORDS:
    - move to COMMIT;
    - fx3_th0Ready = 0 from the next cycle;
    - buffer_count increments on that same edge.
  - A buffer never holds more than BUFFER_WORDS words.
- COMMIT state:
  - The commit counter counts COMMIT_CYCLES cycles, starting from the first cycle with fx3_th0Ready=0.
  - After the final count, if host_stall=0: move to FILL, clear the fill counter and commit counter, set fx3_th0Ready=1 and fx3_th0Watermark=0 on the same edge.
  - If host_stall=1 at that point, remain in COMMIT with ready low until host_stall=0; leave on the first edge with host_stall=0.
  - host_stall has no effect in FILL.
  - Minimum ready-low time is exactly COMMIT_CYCLES cycles.
- Overflow:
  - fx3_nWrite=0 while registered fx3_th0Ready=0 increments overflow_count, saturating.
  - The word is dropped: not checked, last_word unchanged.
  - This covers the cycle immediately after the final buffer word.
- Pattern check, on each accepted word:
  - If check_enable=1 and seed_valid=1 and word != (last_word+1) mod 2^16: mismatch_count increments (saturating) and mismatch_flag is set.
  - Every accepted word then sets seed_valid=1 and loads last_word.
  - check_enable=0 clears seed_valid at each edge; the first word after re-enable only seeds and is never a mismatch.
  - 0xFFFF followed by 0x0000 is legal.
- Simultaneous events:
  - The final-word acceptance and a watermark crossing on the same edge both take effect.
  - Counters cleared by reset take priority over increments on the same edge.

Test Plan:
Bench parameters: BUFFER_WORDS=16, WATERMARK=4, COMMIT_CYCLES=3.
- Reset:
  - Stimulus: hold reset for 2 cycles, then release.
  - Required: all outputs 0 during reset; fx3_th0Ready=1 one cycle after release; watermark=0.
- Fill, check off:
  - Stimulus: check_enable=0, continuous writes of words 0x0000..0x000F.
  - Required: watermark rises the cycle after the 12th word (0x000B); ready falls the cycle after 0x000F; buffer_count=1; last_word=0x000F; ready low exactly 3 cycles, then ready=1 and watermark=0.
- Overflow:
  - Stimulus: continue writing through commit, holding fx3_nWrite=0 for 3 cycles while ready=0.
  - Required: overflow_count=3; last_word stays 0x000F; next accepted word lands in buffer 2 with fill count 1.
- Host stall:
  - Stimulus: host_stall=1 for 10 cycles starting at COMMIT entry.
  - Required: ready low for 10 cycles, then ready=1 on the first edge with host_stall=0; buffer_count increments once only.
- Pattern check:
  - Stimulus: check_enable=1, words 0xFFFE, 0xFFFF, 0x0000, 0x0005, 0x0006.
  - Required: mismatch_count=1 (at 0x0005) and mismatch_flag=1; toggling check_enable low then high and sending 0x1234 adds no mismatch.
- Mid-commit reset:
  - Stimulus: assert reset during COMMIT cycle 2.
  - Required: all counters 0 and state FILL; ready=1 one cycle after release; mismatch_flag cleared.
